// File: rtl/main_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : main_mem_ctrl_pkg
// Description : Shared memory-port constants and a width helper for the
//               behavioural main-memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package main_mem_ctrl_pkg;

    // External memory port geometry shared with the CPU top
    localparam int MEM_ADDR_BITS   = 28;
    localparam int MEM_TAG_BITS    = 5;
    localparam int MEM_DATA_BITS   = 128;
    localparam int MEM_DATA_CYCLES = 4;
    localparam int MEM_LATENCY     = 8;

    // Index width for a counter holding 0..n-1, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/main_mem_ctrl_mem_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : main_mem_ctrl_mem_req_fifo
// Description : In-order synchronous request FIFO with an extra pointer bit
//               to tell full from empty; holds packed {rw, addr, tag}.
// Revision    : 1.0 - initial release
// ============================================================================
module main_mem_ctrl_mem_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wr_ptr;
    logic [c_AW:0]      r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_pop_data = r_mem[r_rd_ptr[c_AW-1:0]];

    // A full FIFO refuses pushes even when a pop happens in the same cycle
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;

    // Pointer update; wrap is implicit in the power-of-two pointer width
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Entry storage, not reset
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/main_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : main_mem_ctrl
// Description : Behavioural DRAM stand-in. Queues tagged line requests,
//               models a fixed access latency before read bursts and writes
//               beats byte-wise into an inferred line array.
// Revision    : 1.0 - initial release
// ============================================================================
module main_mem_ctrl
    import main_mem_ctrl_pkg::*;
#(
    parameter int ADDR_BITS   = MEM_ADDR_BITS,
    parameter int TAG_BITS    = MEM_TAG_BITS,
    parameter int DATA_BITS   = MEM_DATA_BITS,
    parameter int DATA_CYCLES = MEM_DATA_CYCLES,
    parameter int DEPTH_LOG2  = 12,
    parameter int REQ_DEPTH   = 4,
    parameter int LATENCY     = MEM_LATENCY
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   mem_req_valid,
    output logic                   mem_req_ready,
    input  logic                   mem_req_rw,
    input  logic [ADDR_BITS-1:0]   mem_req_addr,
    input  logic [TAG_BITS-1:0]    mem_req_tag,
    input  logic                   mem_req_data_valid,
    output logic                   mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
    output logic                   mem_resp_valid,
    output logic [TAG_BITS-1:0]    mem_resp_tag,
    output logic [DATA_BITS-1:0]   mem_resp_data
);

    localparam int c_BEAT_W  = clog2_min1(DATA_CYCLES);
    localparam int c_LAT_W   = clog2_min1(LATENCY);
    localparam int c_ENTRY_W = 1 + DEPTH_LOG2 + TAG_BITS;
    localparam int c_IDX_W   = DEPTH_LOG2 + c_BEAT_W;
    localparam int c_BYTES   = DATA_BITS / 8;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LAT  = 2'd1;
    localparam logic [1:0] c_ST_RD   = 2'd2;
    localparam logic [1:0] c_ST_WR   = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [DEPTH_LOG2-1:0] r_act_addr;
    logic [TAG_BITS-1:0]   r_act_tag;
    logic [c_LAT_W-1:0]    r_lat_cnt;
    logic [c_BEAT_W-1:0]   r_beat;
    logic                  r_resp_valid;
    logic [TAG_BITS-1:0]   r_resp_tag;
    logic [DATA_BITS-1:0]  r_resp_data;
    logic [DATA_BITS-1:0]  r_mem [2**c_IDX_W];

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [c_ENTRY_W-1:0]  w_head;
    logic                  w_head_rw;
    logic [DEPTH_LOG2-1:0] w_head_addr;
    logic [TAG_BITS-1:0]   w_head_tag;
    logic                  w_wr_fire;
    logic                  w_last_beat;
    logic [c_IDX_W-1:0]    w_index;
    logic                  w_unused_addr_hi;

    // Line addresses above the stored depth alias onto the array
    assign w_unused_addr_hi = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

    assign mem_req_ready      = !w_full;
    assign w_push             = mem_req_valid && mem_req_ready;
    assign w_pop              = (r_state == c_ST_IDLE) && !w_empty;
    assign w_head_rw          = w_head[c_ENTRY_W-1];
    assign w_head_addr        = w_head[TAG_BITS +: DEPTH_LOG2];
    assign w_head_tag         = w_head[TAG_BITS-1:0];
    assign mem_req_data_ready = (r_state == c_ST_WR);
    assign w_wr_fire          = mem_req_data_ready && mem_req_data_valid;
    assign w_last_beat        = (r_beat == c_BEAT_W'(DATA_CYCLES - 1));
    assign w_index            = {r_act_addr, r_beat};

    assign mem_resp_valid     = r_resp_valid;
    assign mem_resp_tag       = r_resp_tag;
    assign mem_resp_data      = r_resp_data;

    main_mem_ctrl_mem_req_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_data ({mem_req_rw, mem_req_addr[DEPTH_LOG2-1:0], mem_req_tag}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Next-state: writes skip the latency phase, reads go through LAT
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (!w_empty) w_state_next = w_head_rw ? c_ST_WR : c_ST_LAT;
            c_ST_LAT:  if (r_lat_cnt == '0) w_state_next = c_ST_RD;
            c_ST_RD:   if (w_last_beat) w_state_next = c_ST_IDLE;
            c_ST_WR:   if (w_wr_fire && w_last_beat) w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= c_ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Active request, latency/beat counters and registered read response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_act_addr   <= '0;
            r_act_tag    <= '0;
            r_lat_cnt    <= '0;
            r_beat       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_tag   <= '0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_act_addr <= w_head_addr;
                        r_act_tag  <= w_head_tag;
                        r_lat_cnt  <= c_LAT_W'(LATENCY - 1);
                        r_beat     <= '0;
                    end
                end
                c_ST_LAT: begin
                    if (r_lat_cnt == '0) r_beat    <= '0;
                    else                 r_lat_cnt <= r_lat_cnt - 1'b1;
                end
                c_ST_RD: begin
                    r_resp_valid <= 1'b1;
                    r_resp_tag   <= r_act_tag;
                    r_resp_data  <= r_mem[w_index];
                    r_beat       <= w_last_beat ? '0 : r_beat + 1'b1;
                end
                c_ST_WR: begin
                    if (w_wr_fire) r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Line storage with per-byte write enable, not reset
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (mem_req_data_mask[b]) r_mem[w_index][b*8 +: 8] <= mem_req_data_bits[b*8 +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_main_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_mem_ctrl
// Description : Directed self-checking bench for main_mem_ctrl with a
//               line-memory model and an expected-beat scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_mem_ctrl;

    localparam int c_AB  = 28;
    localparam int c_TB  = 5;
    localparam int c_DB  = 128;
    localparam int c_DC  = 4;
    localparam int c_LAT = 8;
    localparam int c_MB  = c_DB / 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [c_AB-1:0]   mem_req_addr;
    logic [c_TB-1:0]   mem_req_tag;
    logic              mem_req_data_valid;
    logic              mem_req_data_ready;
    logic [c_DB-1:0]   mem_req_data_bits;
    logic [c_MB-1:0]   mem_req_data_mask;
    logic              mem_resp_valid;
    logic [c_TB-1:0]   mem_resp_tag;
    logic [c_DB-1:0]   mem_resp_data;

    always #5 clk = ~clk;

    main_mem_ctrl #(
        .ADDR_BITS   (c_AB),
        .TAG_BITS    (c_TB),
        .DATA_BITS   (c_DB),
        .DATA_CYCLES (c_DC),
        .DEPTH_LOG2  (12),
        .REQ_DEPTH   (4),
        .LATENCY     (c_LAT)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_tag        (mem_req_tag),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_tag       (mem_resp_tag),
        .mem_resp_data      (mem_resp_data)
    );

    typedef struct packed {
        logic [c_TB-1:0] tag;
        logic [c_DB-1:0] data;
    } exp_t;

    int              checks = 0;
    int              errors = 0;
    exp_t            sb_q[$];
    exp_t            mon_e;
    bit              mon_en = 1'b1;
    logic [c_DB-1:0] model_mem [int];
    logic [c_DB-1:0] wbeat [c_DC];
    logic [c_MB-1:0] wmask [c_DC];

    task automatic check(input string name, input logic [c_DB-1:0] obs, input logic [c_DB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", name, obs, exp);
        end
    endtask

    // Every response beat must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (mon_en && reset_n === 1'b1 && mem_resp_valid === 1'b1) begin
            checks++;
            assert (sb_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_beat: observed tag %0d data %h required no beat", mem_resp_tag, mem_resp_data);
            end
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("resp_tag", c_DB'(mem_resp_tag), c_DB'(mon_e.tag));
                check("resp_data", mem_resp_data, mon_e.data);
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge
    task automatic send_req(input logic rw, input logic [c_AB-1:0] addr, input logic [c_TB-1:0] tag);
        int n;
        n = 0;
        mem_req_valid = 1'b1;
        mem_req_rw    = rw;
        mem_req_addr  = addr;
        mem_req_tag   = tag;
        @(negedge clk);
        while (mem_req_ready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("req_accept_timeout", c_DB'(n < 200), c_DB'(1));
        @(posedge clk);
        #1;
        mem_req_valid = 1'b0;
    endtask

    // Applies the planned line (wbeat/wmask) to the model and issues the write
    task automatic write_req(input logic [c_AB-1:0] addr, input logic [c_TB-1:0] tag);
        for (int i = 0; i < c_DC; i++) begin
            int k;
            logic [c_DB-1:0] cur;
            k = int'(addr) * c_DC + i;
            cur = model_mem.exists(k) ? model_mem[k] : '0;
            for (int b = 0; b < c_MB; b++) begin
                if (wmask[i][b]) cur[b*8 +: 8] = wbeat[i][b*8 +: 8];
            end
            model_mem[k] = cur;
        end
        send_req(1'b1, addr, tag);
    endtask

    // Supplies the planned beats; optional stall of gap_len cycles after beat gap_after
    task automatic write_data(input int gap_after, input int gap_len);
        for (int i = 0; i < c_DC; i++) begin
            int n;
            n = 0;
            mem_req_data_valid = 1'b1;
            mem_req_data_bits  = wbeat[i];
            mem_req_data_mask  = wmask[i];
            @(negedge clk);
            while (mem_req_data_ready !== 1'b1 && n < 200) begin
                n++;
                @(negedge clk);
            end
            check("data_accept_timeout", c_DB'(n < 200), c_DB'(1));
            @(posedge clk);
            #1;
            if (i == gap_after) begin
                mem_req_data_valid = 1'b0;
                mem_req_data_bits  = {c_DB{1'b1}} ^ wbeat[i];
                mem_req_data_mask  = '1;
                repeat (gap_len) @(posedge clk);
                #1;
            end
        end
        mem_req_data_valid = 1'b0;
    endtask

    task automatic read_line(input logic [c_AB-1:0] addr, input logic [c_TB-1:0] tag);
        exp_t e;
        for (int i = 0; i < c_DC; i++) begin
            e.tag  = tag;
            e.data = model_mem[int'(addr) * c_DC + i];
            sb_q.push_back(e);
        end
        send_req(1'b0, addr, tag);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain_all_beats", c_DB'(sb_q.size()), c_DB'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int extra;
        reset_n            = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_tag        = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", c_DB'(mem_req_ready), c_DB'(1));
        check("rst_data_ready", c_DB'(mem_req_data_ready), c_DB'(0));
        check("rst_resp_valid", c_DB'(mem_resp_valid), c_DB'(0));
        check("rst_resp_tag", c_DB'(mem_resp_tag), c_DB'(0));
        check("rst_resp_data", mem_resp_data, '0);
        @(posedge clk);
        #1;

        // Write a line then read it back, measuring read latency
        for (int i = 0; i < c_DC; i++) begin
            wbeat[i] = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 24'h0, 8'(8'hA0 + i)};
            wmask[i] = '1;
        end
        write_req(28'h10, 5'd3);
        write_data(-1, 0);
        read_line(28'h10, 5'd7);
        n = 0;
        @(negedge clk);
        while (mem_resp_valid !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        // One edge for the pop from IDLE, then LATENCY+1 to the first beat
        check("first_beat_latency", c_DB'(n), c_DB'(c_LAT + 2));
        for (int i = 1; i < c_DC; i++) begin
            @(negedge clk);
            check("burst_back_to_back", c_DB'(mem_resp_valid), c_DB'(1));
        end
        @(negedge clk);
        check("burst_valid_drop", c_DB'(mem_resp_valid), c_DB'(0));
        drain();

        // Partial byte mask on beat 1 over an all-ones line
        for (int i = 0; i < c_DC; i++) begin
            wbeat[i] = '1;
            wmask[i] = '1;
        end
        write_req(28'h20, 5'd1);
        write_data(-1, 0);
        for (int i = 0; i < c_DC; i++) begin
            wbeat[i] = '0;
            wmask[i] = (i == 1) ? 16'h000F : 16'h0000;
        end
        write_req(28'h20, 5'd2);
        write_data(-1, 0);
        check("model_partial_beat1", model_mem[32'h20 * c_DC + 1], {{96{1'b1}}, 32'h0});
        read_line(28'h20, 5'd4);
        drain();

        // Write data stalls for 5 cycles between beats 1 and 2
        for (int i = 0; i < c_DC; i++) begin
            wbeat[i] = {96'hB0B1_B2B3_B4B5_B6B7_B8B9_BABB, 32'(32'hB000_0000 + i)};
            wmask[i] = '1;
        end
        write_req(28'h30, 5'd5);
        write_data(1, 5);
        // Stray beat after the line completed must not be consumed
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_extra_data_ready", c_DB'(mem_req_data_ready), c_DB'(0));
        end
        @(posedge clk);
        #1 mem_req_data_valid = 1'b0;
        read_line(28'h30, 5'd6);
        drain();

        // Fill the FIFO behind a write waiting for data
        for (int i = 0; i < c_DC; i++) begin
            wbeat[i] = {64'hC0C0_C0C0_C0C0_C0C0, 64'(64'hC0 + i)};
            wmask[i] = '1;
        end
        write_req(28'h40, 5'd8);
        read_line(28'h10, 5'd10);
        read_line(28'h20, 5'd11);
        read_line(28'h30, 5'd12);
        read_line(28'h40, 5'd13);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = 28'h10;
        mem_req_tag   = 5'd14;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fifo_full_ready", c_DB'(mem_req_ready), c_DB'(0));
        end
        @(posedge clk);
        #1 mem_req_valid = 1'b0;
        write_data(-1, 0);
        read_line(28'h10, 5'd14);
        drain();

        // Reset asserted during read beat 2
        mon_en = 1'b0;
        send_req(1'b0, 28'h10, 5'd9);
        n = 0;
        @(negedge clk);
        while (mem_resp_valid !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("abort_first_beat_seen", c_DB'(n < 100), c_DB'(1));
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort_beat2_valid", c_DB'(mem_resp_valid), c_DB'(1));
        check("abort_beat2_tag", c_DB'(mem_resp_tag), c_DB'(9));
        check("abort_beat2_data", mem_resp_data, model_mem[32'h10 * c_DC + 2]);
        reset_n = 1'b0;
        #1;
        check("abort_valid_async", c_DB'(mem_resp_valid), c_DB'(0));
        check("abort_data_cleared", mem_resp_data, '0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_resp_valid !== 1'b0) extra++;
        end
        check("abort_no_more_beats", c_DB'(extra), c_DB'(0));
        check("abort_req_ready", c_DB'(mem_req_ready), c_DB'(1));
        check("abort_data_ready", c_DB'(mem_req_data_ready), c_DB'(0));
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Storage survives reset and the controller resumes
        read_line(28'h30, 5'd15);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
